// File: rtl/aurora_64b66b_rst_seq.sv
// aurora_64b66b_rst_seq
// Reset/bring-up sequencer for one or more Aurora 64B66B cores, running on
// the free-running init clock. Each channel has its own FSM, counter and
// channel_up synchroniser, and channels never interact.
//
// Ports
//   INIT_CLK_i  in   free-running init clock
//   RESET       in   asynchronous active-high reset for every flop
//   channel_up  in   per-core channel_up from the user_clk domain
//   retrain     in   single-cycle request to restart channel i
//   pma_init    out  PMA init to core i
//   reset_pb    out  system reset to core i
//   link_up     out  channel i is in UP
//   failed      out  channel i is in FAILED
//   retry_cnt   out  consecutive timeout count, channel i at [i*RW +: RW]
//
// state   | meaning
// DELAY   | pma_init and reset_pb high, waiting PMA_INIT_DELAY cycles
// PULSE   | pma_init and reset_pb high, PMA_PULSE_CYCLES more cycles
// HOLD    | pma_init low, reset_pb high for RESET_PB_HOLD cycles
// WAIT_UP | both released, waiting up to CHUP_TIMEOUT for channel_up
// UP      | link up; loss of channel_up restarts the sequence
// FAILED  | retries exhausted, core held in reset until retrain/RESET
module aurora_64b66b_rst_seq #(
  parameter int NUM_CHANNELS     = 1,
  parameter int PMA_INIT_DELAY   = 128,
  parameter int PMA_PULSE_CYCLES = 16777215,
  parameter int RESET_PB_HOLD    = 64,
  parameter int CHUP_TIMEOUT     = 67108864,
  parameter int MAX_RETRIES      = 3,
  parameter int SYNC_STAGES      = 2,
  localparam int RW = $clog2(MAX_RETRIES + 1)
) (
  input  logic                       INIT_CLK_i,
  input  logic                       RESET,
  input  logic [NUM_CHANNELS-1:0]    channel_up,
  input  logic [NUM_CHANNELS-1:0]    retrain,
  output logic [NUM_CHANNELS-1:0]    pma_init,
  output logic [NUM_CHANNELS-1:0]    reset_pb,
  output logic [NUM_CHANNELS-1:0]    link_up,
  output logic [NUM_CHANNELS-1:0]    failed,
  output logic [NUM_CHANNELS*RW-1:0] retry_cnt
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXC = max_of(max_of(PMA_INIT_DELAY, PMA_PULSE_CYCLES),
                               max_of(RESET_PB_HOLD, CHUP_TIMEOUT));
  localparam int CW = $clog2(MAXC) + 1;

  // Terminal counts: a phase of N cycles ends on the edge where cnt == N-1.
  localparam logic [CW-1:0] D_LAST = CW'(PMA_INIT_DELAY - 1);
  localparam logic [CW-1:0] P_LAST = CW'(PMA_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST = CW'(RESET_PB_HOLD - 1);
  localparam logic [CW-1:0] T_LAST = CW'(CHUP_TIMEOUT - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(MAX_RETRIES);

  localparam logic [2:0] S_DELAY   = 3'd0;
  localparam logic [2:0] S_PULSE   = 3'd1;
  localparam logic [2:0] S_HOLD    = 3'd2;
  localparam logic [2:0] S_WAIT_UP = 3'd3;
  localparam logic [2:0] S_UP      = 3'd4;
  localparam logic [2:0] S_FAILED  = 3'd5;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   chup_s;
    logic [2:0]             state;
    logic [CW-1:0]          cnt;
    logic [RW-1:0]          rcnt;
    logic [RW-1:0]          rnext;

    always_ff @(posedge INIT_CLK_i or posedge RESET) begin
      if (RESET) sync <= '0;
      else       sync <= {sync[SYNC_STAGES-2:0], channel_up[i]};
    end

    assign chup_s = sync[SYNC_STAGES-1];
    assign rnext  = rcnt + RW'(1);

    always_ff @(posedge INIT_CLK_i or posedge RESET) begin
      if (RESET) begin
        state <= S_DELAY;
        cnt   <= '0;
        rcnt  <= '0;
      end else if (retrain[i]) begin
        // Retrain out of FAILED starts a fresh retry budget.
        state <= S_DELAY;
        cnt   <= '0;
        if (state == S_FAILED) rcnt <= '0;
      end else begin
        case (state)
          S_DELAY: begin
            if (cnt == D_LAST) begin
              state <= S_PULSE;
              cnt   <= '0;
            end else cnt <= cnt + CW'(1);
          end
          S_PULSE: begin
            if (cnt == P_LAST) begin
              state <= S_HOLD;
              cnt   <= '0;
            end else cnt <= cnt + CW'(1);
          end
          S_HOLD: begin
            if (cnt == H_LAST) begin
              state <= S_WAIT_UP;
              cnt   <= '0;
            end else cnt <= cnt + CW'(1);
          end
          S_WAIT_UP: begin
            // channel_up wins over a timeout landing on the same cycle.
            if (chup_s) begin
              state <= S_UP;
              cnt   <= '0;
              rcnt  <= '0;
            end else if (cnt == T_LAST) begin
              state <= (rnext == R_MAX) ? S_FAILED : S_DELAY;
              cnt   <= '0;
              rcnt  <= rnext;
            end else cnt <= cnt + CW'(1);
          end
          S_UP: begin
            if (!chup_s) begin
              state <= S_DELAY;
              cnt   <= '0;
            end
          end
          S_FAILED: cnt <= '0;
          default: begin
            state <= S_DELAY;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign pma_init[i] = (state == S_DELAY) || (state == S_PULSE);
    assign reset_pb[i] = (state == S_DELAY) || (state == S_PULSE) ||
                         (state == S_HOLD)  || (state == S_FAILED);
    assign link_up[i]  = (state == S_UP);
    assign failed[i]   = (state == S_FAILED);
    assign retry_cnt[i*RW +: RW] = rcnt;
  end

endmodule

// File: tb/tb_aurora_64b66b_rst_seq.sv
module tb_aurora_64b66b_rst_seq;

  localparam int N  = 2;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  channel_up = '0;
  logic [N-1:0]  retrain = '0;
  logic [N-1:0]  pma_init;
  logic [N-1:0]  reset_pb;
  logic [N-1:0]  link_up;
  logic [N-1:0]  failed;
  logic [N*RW-1:0] retry_cnt;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  aurora_64b66b_rst_seq #(
    .NUM_CHANNELS(N), .PMA_INIT_DELAY(4), .PMA_PULSE_CYCLES(8),
    .RESET_PB_HOLD(2), .CHUP_TIMEOUT(20), .MAX_RETRIES(2), .SYNC_STAGES(2)
  ) dut (
    .INIT_CLK_i(clk), .RESET(rst), .channel_up(channel_up), .retrain(retrain),
    .pma_init(pma_init), .reset_pb(reset_pb), .link_up(link_up),
    .failed(failed), .retry_cnt(retry_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  // Advance to just after edge e (edges counted from RESET release).
  task automatic to_edge(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      #1;
      edge_n++;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pma"},   32'(pma_init),  32'h3);
    chk({tag, "_rpb"},   32'(reset_pb),  32'h3);
    chk({tag, "_lup"},   32'(link_up),   32'h0);
    chk({tag, "_fail"},  32'(failed),    32'h0);
    chk({tag, "_retry"}, 32'(retry_cnt), 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst = 1'b0;
    edge_n = 0;

    // Clean bring-up on ch0; ch1 never sees channel_up and times out.
    to_edge(11); chk("pma_hi_e11", 32'(pma_init), 32'h3);
    to_edge(12); chk("pma_lo_e12", 32'(pma_init), 32'h0);
                 chk("rpb_hi_e12", 32'(reset_pb), 32'h3);
    to_edge(13); chk("rpb_hi_e13", 32'(reset_pb), 32'h3);
    to_edge(14); chk("rpb_lo_e14", 32'(reset_pb), 32'h0);
    to_edge(15); channel_up[0] = 1'b1;
    to_edge(17); chk("lup0_e17", 32'(link_up[0]), 32'h0);
    to_edge(18); chk("lup0_e18", 32'(link_up[0]), 32'h1);
                 chk("retry0_up", 32'(retry_cnt[1:0]), 32'h0);

    to_edge(33); chk("retry1_e33", 32'(retry_cnt[3:2]), 32'h0);
                 chk("pma1_e33",   32'(pma_init[1]),    32'h0);
    to_edge(34); chk("retry1_e34", 32'(retry_cnt[3:2]), 32'h1);
                 chk("pma1_e34",   32'(pma_init[1]),    32'h1);
    to_edge(46); chk("pma1_e46",   32'(pma_init[1]),    32'h0);
    to_edge(67); chk("fail1_e67",  32'(failed[1]),      32'h0);
    to_edge(68); chk("fail1_e68",  32'(failed[1]),      32'h1);
                 chk("retry1_e68", 32'(retry_cnt[3:2]), 32'h2);
                 chk("rpb1_fail",  32'(reset_pb[1]),    32'h1);
                 chk("pma1_fail",  32'(pma_init[1]),    32'h0);
    to_edge(70); chk("fail1_hold", 32'(failed[1]),      32'h1);
                 chk("retry1_frz", 32'(retry_cnt[3:2]), 32'h2);

    // Retrain ch1 out of FAILED; sequence restarts with the same edge counts.
    retrain[1] = 1'b1;
    to_edge(71); retrain[1] = 1'b0;
                 chk("rt_fail1",  32'(failed[1]),      32'h0);
                 chk("rt_retry1", 32'(retry_cnt[3:2]), 32'h0);
                 chk("rt_pma1",   32'(pma_init[1]),    32'h1);
                 chk("rt_lup0",   32'(link_up[0]),     32'h1);
    to_edge(82); chk("rt_pma1_82", 32'(pma_init[1]), 32'h1);
    to_edge(83); chk("rt_pma1_83", 32'(pma_init[1]), 32'h0);
    to_edge(84); chk("rt_rpb1_84", 32'(reset_pb[1]), 32'h1);
    to_edge(85); chk("rt_rpb1_85", 32'(reset_pb[1]), 32'h0);
    channel_up[1] = 1'b1;
    to_edge(87); chk("lup1_87", 32'(link_up[1]), 32'h0);
    to_edge(88); chk("lup1_88", 32'(link_up[1]), 32'h1);

    // Link loss on ch1: reassertion three cycles later, ch0 untouched.
    to_edge(90); channel_up[1] = 1'b0;
    to_edge(92); chk("loss_lup1_92", 32'(link_up[1]),  32'h1);
                 chk("loss_pma1_92", 32'(pma_init[1]), 32'h0);
    to_edge(93); chk("loss_pma1", 32'(pma_init[1]),    32'h1);
                 chk("loss_rpb1", 32'(reset_pb[1]),    32'h1);
                 chk("loss_lup1", 32'(link_up[1]),     32'h0);
                 chk("loss_rty1", 32'(retry_cnt[3:2]), 32'h0);
                 chk("loss_ch0",  32'({link_up[0], pma_init[0], reset_pb[0]}), 32'h4);

    // chup_s rises exactly on the timeout cycle (WAIT_UP entered at 107).
    to_edge(107); chk("co_rpb1_107", 32'(reset_pb[1]), 32'h0);
    to_edge(124); channel_up[1] = 1'b1;
    to_edge(126); chk("co_lup1_126", 32'(link_up[1]), 32'h0);
    to_edge(127); chk("co_lup1_127", 32'(link_up[1]), 32'h1);
                  chk("co_rty1_127", 32'(retry_cnt[3:2]), 32'h0);
                  chk("co_pma1_127", 32'(pma_init[1]), 32'h0);

    // retrain coincident with chup_s fall: DELAY with a fresh counter.
    to_edge(130); channel_up[1] = 1'b0;
    to_edge(132); retrain[1] = 1'b1;
    to_edge(133); retrain[1] = 1'b0;
                  chk("rf_pma1_133", 32'(pma_init[1]), 32'h1);
                  chk("rf_lup1_133", 32'(link_up[1]),  32'h0);
                  chk("rf_lup0_133", 32'(link_up[0]),  32'h1);

    // Async reset while ch1 is in PULSE.
    to_edge(140);
    #2 rst = 1'b1;
    #1 chk_reset_vals("arst");
    to_edge(141);
    chk("arst_hold_pma", 32'(pma_init), 32'h3);
    rst = 1'b0;
    edge_n = 0;
    to_edge(11); chk("rel_pma_e11", 32'(pma_init), 32'h3);
    to_edge(12); chk("rel_pma_e12", 32'(pma_init), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
